// File: rtl/conv55_window_if.sv
// Pixel-in / window-out handshake bundle for the 5x5 window generator.
interface conv55_window_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 5
);
  localparam int unsigned WIN_W = K * K * DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic              win_valid;
  logic              win_ready;
  logic [WIN_W-1:0]  win_data;
  logic              win_last;

  // Producer of pixels and consumer of windows.
  modport master (
    output in_valid, in_sof, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_last
  );

  // The window generator itself.
  modport slave (
    input  in_valid, in_sof, in_data, win_ready,
    output in_ready, win_valid, win_data, win_last
  );
endinterface

// File: rtl/conv55_window_gen.sv
// Raster pixel stream to KxK sliding-window generator with line buffers
// and a single backpressure-absorbing output register.
module conv55_window_gen #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  conv55_window_if.slave  bus
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned WIN_W = K * K * DATA_W;

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  pos_col_c;
  logic [ROW_W-1:0]  pos_row_c;
  logic [COL_W-1:0]  col_nxt_c;
  logic [ROW_W-1:0]  row_nxt_c;

  logic [DATA_W-1:0] line_buf [K-1][IMG_W];
  logic [DATA_W-1:0] win_q    [K][K];
  logic [DATA_W-1:0] win_nxt_c[K][K];
  logic [DATA_W-1:0] new_col_c[K];
  logic [WIN_W-1:0]  win_flat_c;

  logic              win_valid_q;
  logic              win_last_q;
  logic [WIN_W-1:0]  win_data_q;

  logic              in_ready_c;
  logic              accept_c;
  logic              emit_c;
  logic              last_c;

  // The output register can take a new window when empty or being drained.
  assign in_ready_c    = ~win_valid_q | bus.win_ready;
  assign accept_c      = bus.in_valid & in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.win_data  = win_data_q;

  // Position of the pixel on the bus; a start-of-frame forces (0,0).
  always_comb begin
    pos_col_c = col_q;
    pos_row_c = row_q;
    if (bus.in_sof) begin
      pos_col_c = '0;
      pos_row_c = '0;
    end
  end

  // Raster position advance with wrap at end of row and end of frame.
  always_comb begin
    col_nxt_c = pos_col_c + COL_W'(1);
    row_nxt_c = pos_row_c;
    if (pos_col_c == COL_W'(IMG_W - 1)) begin
      col_nxt_c = '0;
      if (pos_row_c == ROW_W'(IMG_H - 1)) begin
        row_nxt_c = '0;
      end else begin
        row_nxt_c = pos_row_c + ROW_W'(1);
      end
    end
  end

  // Next window: shift left one column, append stored column plus new pixel.
  always_comb begin
    for (int r = 0; r < int'(K) - 1; r++) begin
      new_col_c[r] = line_buf[r][pos_col_c];
    end
    new_col_c[K-1] = bus.in_data;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K); c++) begin
        if (c < int'(K) - 1) begin
          win_nxt_c[r][c] = win_q[r][c+1];
        end else begin
          win_nxt_c[r][c] = new_col_c[r];
        end
      end
    end
  end

  // Flatten with element 0 at the top-left, row-major.
  always_comb begin
    win_flat_c = '0;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K); c++) begin
        win_flat_c[DATA_W*(K*r+c) +: DATA_W] = win_nxt_c[r][c];
      end
    end
  end

  // A full window exists only once K-1 rows and K-1 columns precede the pixel.
  always_comb begin
    emit_c = accept_c &&
             (pos_row_c >= ROW_W'(K - 1)) &&
             (pos_col_c >= COL_W'(K - 1));
    last_c = (pos_row_c == ROW_W'(IMG_H - 1)) &&
             (pos_col_c == COL_W'(IMG_W - 1));
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept_c) begin
      col_q <= col_nxt_c;
      row_q <= row_nxt_c;
    end
  end

  // Window shift register and line buffers; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      win_q <= win_nxt_c;
      for (int r = 0; r < int'(K) - 2; r++) begin
        line_buf[r][pos_col_c] <= line_buf[r+1][pos_col_c];
      end
      line_buf[K-2][pos_col_c] <= bus.in_data;
    end
  end

  // Output register: load on emit, hold under backpressure, drain on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_data_q  <= '0;
    end else if (emit_c) begin
      win_valid_q <= 1'b1;
      win_last_q  <= last_c;
      win_data_q  <= win_flat_c;
    end else if (bus.win_ready) begin
      win_valid_q <= 1'b0;
    end
  end
endmodule
